// File: rtl/panel_arbiter_if.sv
// ---------------------------------------------------------------------------
// panel_arbiter_if
// Groups the request, pattern and status signals of the panel arbiter.
//   req_i    [2:0]  per-requester panel requests (0 student, 1 HPS, 2 heartbeat)
//   led_i    [23:0] requester LED patterns, requester k on bits [8k+7:8k]
//   seg_i    [23:0] requester SEG patterns (active-low), same packing
//   grant_o  [2:0]  one-hot current owner, 0 when nobody owns the panel
//   led_o    [7:0]  arbitrated LED drive
//   seg_o    [7:0]  arbitrated SEG drive
//   busy_o          high whenever the arbiter is not idle
//   tick_o          one-cycle prescaler strobe
//   hb_o     [3:0]  one-hot rotating heartbeat
// The slave modport is the arbiter's view, the master modport the requesters'.
// ---------------------------------------------------------------------------
interface panel_arbiter_if;
   logic [2:0]  req_i;
   logic [23:0] led_i;
   logic [23:0] seg_i;
   logic [2:0]  grant_o;
   logic [7:0]  led_o;
   logic [7:0]  seg_o;
   logic        busy_o;
   logic        tick_o;
   logic [3:0]  hb_o;

   modport slave (
      input  req_i, led_i, seg_i,
      output grant_o, led_o, seg_o, busy_o, tick_o, hb_o
   );

   modport master (
      output req_i, led_i, seg_i,
      input  grant_o, led_o, seg_o, busy_o, tick_o, hb_o
   );
endinterface

// File: rtl/panel_arbiter.sv
// ---------------------------------------------------------------------------
// panel_arbiter
// Shares one LED/7-segment panel between three requesters with round-robin
// selection, a minimum hold time before preemption and a one-cycle blanking
// gap on every hand-over.
//   fpga_clk_50   single clock, all state changes on its rising edge
//   fpga_rst_n    synchronous active-low reset
//   bus           panel_arbiter_if.slave (requests, patterns, grant, status)
// Parameters:
//   TICK_DIV      tick period in clock cycles (>= 2)
//   HOLD_TICKS    ticks an owner keeps the panel before it can be preempted
// ---------------------------------------------------------------------------
module panel_arbiter #(
   parameter int TICK_DIV   = 50000000,
   parameter int HOLD_TICKS = 2
) (
   input  logic            fpga_clk_50,
   input  logic            fpga_rst_n,
   panel_arbiter_if.slave  bus
);

   localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [7:0]       HOLD_MAX = 8'(HOLD_TICKS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN    = 2'd1,
      SWITCH = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [1:0]       r_owner;
   logic [1:0]       w_nextOwner;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_holdCnt;
   logic [3:0]       r_hb;
   logic [7:0]       r_led;
   logic [7:0]       r_seg;
   logic             r_armed;
   logic             w_tick;
   logic             w_ownReq;
   logic [7:0]       w_ownLed;
   logic [7:0]       w_ownSeg;
   logic [2:0]       w_others;
   logic [1:0]       w_pick;

   // Round-robin search starting just after the last owner and wrapping
   // back to the last owner itself as the final candidate.
   function automatic logic [1:0] rrPick(input logic [1:0] last, input logic [2:0] req);
      logic [1:0] c1;
      logic [1:0] c2;
      c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
      c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
      if (req[c1])
         return c1;
      else if (req[c2])
         return c2;
      else
         return last;
   endfunction

   assign w_tick   = (r_cnt == CNT_LAST);
   assign w_others = bus.req_i & ~(3'b001 << r_owner);
   assign w_pick   = rrPick(r_owner, bus.req_i);

   // Select the current owner's request bit and panel patterns.
   always_comb begin
      w_ownReq = 1'b0;
      w_ownLed = 8'h00;
      w_ownSeg = 8'hFF;
      case (r_owner)
         2'd0: begin
            w_ownReq = bus.req_i[0];
            w_ownLed = bus.led_i[7:0];
            w_ownSeg = bus.seg_i[7:0];
         end
         2'd1: begin
            w_ownReq = bus.req_i[1];
            w_ownLed = bus.led_i[15:8];
            w_ownSeg = bus.seg_i[15:8];
         end
         2'd2: begin
            w_ownReq = bus.req_i[2];
            w_ownLed = bus.led_i[23:16];
            w_ownSeg = bus.seg_i[23:16];
         end
         default: begin
            w_ownReq = 1'b0;
         end
      endcase
   end

   // Next-state logic. IDLE waits one cycle after reset release (r_armed)
   // so that no grant appears on the first edge after reset goes away.
   // The owner register keeps the previous owner through SWITCH, which is
   // what the round-robin pick needs.
   always_comb begin
      w_nextState = r_state;
      w_nextOwner = r_owner;
      case (r_state)
         IDLE: begin
            if (r_armed && (|bus.req_i)) begin
               w_nextState = OWN;
               w_nextOwner = w_pick;
            end
         end
         OWN: begin
            if (!w_ownReq ||
                ((r_holdCnt == HOLD_MAX) && w_tick && (|w_others))) begin
               w_nextState = SWITCH;
            end
         end
         SWITCH: begin
            if (|bus.req_i) begin
               w_nextState = OWN;
               w_nextOwner = w_pick;
            end else begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State, prescaler, heartbeat, hold counter and registered panel drive.
   // hold_cnt is cleared whenever not in OWN, so every OWN entry starts at 0.
   always_ff @(posedge fpga_clk_50) begin
      if (!fpga_rst_n) begin
         r_state   <= IDLE;
         r_owner   <= 2'd2;
         r_cnt     <= '0;
         r_holdCnt <= 8'd0;
         r_hb      <= 4'b0001;
         r_led     <= 8'h00;
         r_seg     <= 8'hFF;
         r_armed   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_owner <= w_nextOwner;
         r_armed <= 1'b1;
         r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
         if (w_tick)
            r_hb <= {r_hb[2:0], r_hb[3]};
         if (r_state != OWN)
            r_holdCnt <= 8'd0;
         else if (w_tick && (r_holdCnt != HOLD_MAX))
            r_holdCnt <= r_holdCnt + 8'd1;
         if (r_state == OWN) begin
            r_led <= w_ownLed;
            r_seg <= w_ownSeg;
         end else begin
            r_led <= 8'h00;
            r_seg <= 8'hFF;
         end
      end
   end

   assign bus.grant_o = (r_state == OWN) ? (3'b001 << r_owner) : 3'b000;
   assign bus.busy_o  = (r_state != IDLE);
   assign bus.tick_o  = w_tick;
   assign bus.hb_o    = r_hb;
   assign bus.led_o   = r_led;
   assign bus.seg_o   = r_seg;

endmodule
